// File: rtl/vga_noise_overlay_pkg.sv
// Shared encodings for the VGA noise overlay: mode and burst-FSM enums,
// TinyVGA PMOD bit positions and the clean-byte packing helper.
package vga_noise_overlay_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_BURST  = 2'b10,
        MODE_FROZEN = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_COOL  = 2'b10
    } burst_state_e;

    // PMOD byte layout {hsync,B0,G0,R0,vsync,B1,G1,R1}
    localparam int PMOD_HSYNC = 7;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_R1    = 0;

    // rgb_in layout {R1,R0,G1,G0,B1,B0}
    localparam int RGB_R1 = 5;
    localparam int RGB_R0 = 4;
    localparam int RGB_G1 = 3;
    localparam int RGB_G0 = 2;
    localparam int RGB_B1 = 1;
    localparam int RGB_B0 = 0;

    // Bits that may ever carry noise; sync bits are always clean.
    localparam logic [7:0] PMOD_COLOUR_MASK = 8'h77;

    function automatic logic [7:0] pmod_pack(
        input logic       hsync,
        input logic       vsync,
        input logic       display_on,
        input logic [5:0] rgb
    );
        logic [5:0] colour;
        logic [7:0] packed_byte;
        colour = display_on ? rgb : 6'd0;
        packed_byte             = '0;
        packed_byte[PMOD_HSYNC] = hsync;
        packed_byte[PMOD_B0]    = colour[RGB_B0];
        packed_byte[PMOD_G0]    = colour[RGB_G0];
        packed_byte[PMOD_R0]    = colour[RGB_R0];
        packed_byte[PMOD_VSYNC] = vsync;
        packed_byte[PMOD_B1]    = colour[RGB_B1];
        packed_byte[PMOD_G1]    = colour[RGB_G1];
        packed_byte[PMOD_R1]    = colour[RGB_R1];
        return packed_byte;
    endfunction

endpackage

// File: rtl/vga_noise_overlay_pcg8_gen.sv
// 16-bit LCG state with an xorshift/rotate permutation giving 8 noise bits
// per cycle; reload snaps the state back to SEED instead of advancing.
module pcg8_gen #(
    parameter logic [15:0] MUL  = 16'h5851,
    parameter logic [15:0] INC  = 16'h1405,
    parameter logic [15:0] SEED = 16'h0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reload,
    output logic [7:0] noise
);

    logic [15:0] state_reg;
    logic [15:0] state_next;
    logic [7:0]  mix_x;
    logic [2:0]  rot;
    logic [15:0] rot_pair;

    always_comb begin
        state_next = reload ? SEED : (state_reg * MUL + INC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output is taken from the current state, before this cycle's advance.
    assign mix_x    = 8'(((state_reg >> 2) ^ state_reg) >> 3);
    assign rot      = state_reg[5:3];
    assign rot_pair = {mix_x, mix_x} >> rot;
    assign noise    = rot_pair[7:0];

endmodule

// File: rtl/vga_noise_overlay.sv
// Registers a TinyVGA PMOD byte from the timing/pattern inputs and XORs in
// PCG noise on the colour bits, gated by mode and a frame-based burst FSM.
module vga_noise_overlay
    import vga_noise_overlay_pkg::*;
#(
    parameter logic [15:0] PCG_MUL           = 16'h5851,
    parameter logic [15:0] PCG_INC           = 16'h1405,
    parameter logic [15:0] SEED              = 16'h0000,
    parameter bit          VSYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [5:0] rgb_in,
    input  logic [7:0] noise_mask,
    input  logic [1:0] mode,
    input  logic [3:0] burst_len,
    output logic [7:0] uo_out,
    output logic [9:0] frame_count,
    output logic       noise_active
);

    mode_e        mode_sel;
    burst_state_e state_reg;
    burst_state_e state_next;
    logic [3:0]   frames_left_reg;
    logic [3:0]   frames_left_next;
    logic         vsync_act_in;
    logic         vsync_act_reg;
    logic         frame_start;
    logic [9:0]   frame_count_reg;
    logic         noise_en;
    logic         pcg_reload;
    logic [7:0]   noise;
    logic [7:0]   clean_byte;
    logic [7:0]   uo_next;
    logic [7:0]   uo_reg;

    assign mode_sel = mode_e'(mode);

    // Frame start is the edge where the registered vsync turns active.
    assign vsync_act_in = VSYNC_ACTIVE_HIGH ? vsync_in : ~vsync_in;
    assign frame_start  = vsync_act_in & ~vsync_act_reg;

    assign pcg_reload = frame_start & (mode_sel == MODE_FROZEN);

    pcg8_gen #(
        .MUL  (PCG_MUL),
        .INC  (PCG_INC),
        .SEED (SEED)
    ) u_pcg (
        .clk    (clk),
        .reset  (reset),
        .reload (pcg_reload),
        .noise  (noise)
    );

    always_comb begin
        state_next       = state_reg;
        frames_left_next = frames_left_reg;
        if (mode_sel != MODE_BURST) begin
            state_next       = ST_IDLE;
            frames_left_next = '0;
        end else if (frame_start) begin
            case (state_reg)
                ST_IDLE: begin
                    if (burst_len != 4'd0) begin
                        state_next       = ST_BURST;
                        frames_left_next = burst_len;
                    end
                end
                ST_BURST, ST_COOL: begin
                    if (frames_left_reg == 4'd1) begin
                        // burst_len is only sampled here, at a period boundary
                        if (burst_len == 4'd0) begin
                            state_next       = ST_IDLE;
                            frames_left_next = '0;
                        end else begin
                            state_next       = (state_reg == ST_BURST) ? ST_COOL : ST_BURST;
                            frames_left_next = burst_len;
                        end
                    end else begin
                        frames_left_next = frames_left_reg - 4'd1;
                    end
                end
                default: begin
                    state_next       = ST_IDLE;
                    frames_left_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            frames_left_reg <= '0;
        end else begin
            state_reg       <= state_next;
            frames_left_reg <= frames_left_next;
        end
    end

    always_comb begin
        noise_en = (mode_sel == MODE_CONT) || (mode_sel == MODE_FROZEN) ||
                   ((mode_sel == MODE_BURST) && (state_reg == ST_BURST));
    end

    assign clean_byte = pmod_pack(hsync_in, vsync_in, display_on, rgb_in);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign uo_next[gi] = clean_byte[gi] ^
                                 (noise[gi] & noise_mask[gi] & noise_en &
                                  PMOD_COLOUR_MASK[gi] & display_on);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uo_reg          <= 8'h00;
            vsync_act_reg   <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            uo_reg        <= uo_next;
            vsync_act_reg <= vsync_act_in;
            if (frame_start) begin
                frame_count_reg <= frame_count_reg + 10'd1;
            end
        end
    end

    assign uo_out       = uo_reg;
    assign frame_count  = frame_count_reg;
    assign noise_active = noise_en;

endmodule

// File: tb/tb_vga_noise_overlay.sv
// Self-checking bench: frame-level reference model compared every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_vga_noise_overlay;

    localparam logic [15:0] TB_MUL  = 16'h5851;
    localparam logic [15:0] TB_INC  = 16'h1405;
    localparam logic [15:0] TB_SEED = 16'h0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       display_on = 1'b0;
    logic [5:0] rgb_in = 6'h0;
    logic [7:0] noise_mask = 8'h0;
    logic [1:0] mode = 2'b00;
    logic [3:0] burst_len = 4'h0;
    logic [7:0] uo_out;
    logic [9:0] frame_count;
    logic       noise_active;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    vga_noise_overlay #(
        .PCG_MUL           (TB_MUL),
        .PCG_INC           (TB_INC),
        .SEED              (TB_SEED),
        .VSYNC_ACTIVE_HIGH (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .display_on   (display_on),
        .rgb_in       (rgb_in),
        .noise_mask   (noise_mask),
        .mode         (mode),
        .burst_len    (burst_len),
        .uo_out       (uo_out),
        .frame_count  (frame_count),
        .noise_active (noise_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] perm(input logic [15:0] s);
        int unsigned si, x, r;
        si = s;
        x  = (((si >> 2) ^ si) >> 3) & 32'hFF;
        r  = (si >> 3) & 32'h7;
        return 8'(((x >> r) | (x << (8 - r))) & 32'hFF);
    endfunction

    function automatic logic [15:0] pcg_next(input logic [15:0] s);
        int unsigned si;
        si = s;
        return 16'((si * TB_MUL + TB_INC) % 65536);
    endfunction

    function automatic logic [7:0] clean(input logic h, input logic v, input logic d,
                                         input logic [5:0] c);
        logic [5:0] cc;
        cc = d ? c : 6'h0;
        return {h, cc[0], cc[2], cc[4], v, cc[1], cc[3], cc[5]};
    endfunction

    typedef struct {
        logic [15:0] s;
        logic        vs;     // registered vsync is at active level
        logic [9:0]  fc;
        logic [7:0]  uo;
        logic        ep;     // inside a burst episode
        logic        noisy;  // current period is a noisy one
        int          len;
        int          pos;    // frames elapsed in current period
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.s = TB_SEED; r.vs = 1'b0; r.fc = '0; r.uo = 8'h00;
        r.ep = 1'b0; r.noisy = 1'b0; r.len = 0; r.pos = 0;
        return r;
    endfunction

    function automatic logic model_en(input model_t cur);
        return (mode == 2'b01) || (mode == 2'b11) ||
               ((mode == 2'b10) && cur.ep && cur.noisy);
    endfunction

    function automatic model_t step(input model_t cur);
        model_t n;
        logic fs;
        logic [7:0] nz;
        n  = cur;
        fs = (vsync_in == 1'b0) && !cur.vs;
        nz = perm(cur.s) & noise_mask & ((model_en(cur) && display_on) ? 8'h77 : 8'h00);
        n.uo = clean(hsync_in, vsync_in, display_on, rgb_in) ^ nz;
        n.s  = (mode == 2'b11 && fs) ? TB_SEED : pcg_next(cur.s);
        if (fs) n.fc = cur.fc + 10'd1;
        if (mode != 2'b10) begin
            n.ep = 1'b0;
        end else if (fs) begin
            if (!cur.ep) begin
                if (burst_len != 0) begin
                    n.ep = 1'b1; n.noisy = 1'b1; n.len = burst_len; n.pos = 0;
                end
            end else begin
                n.pos = cur.pos + 1;
                if (n.pos >= cur.len) begin
                    n.noisy = !cur.noisy;
                    n.len   = burst_len;
                    n.pos   = 0;
                    if (burst_len == 0) n.ep = 1'b0;
                end
            end
        end
        n.vs = (vsync_in == 1'b0);
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= step(m);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("uo_out", 32'(uo_out), 32'(m.uo));
            check("frame_count", 32'(frame_count), 32'(m.fc));
            check("noise_active", 32'(noise_active), 32'(model_en(m)));
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit          pat[6];
        logic [5:0]  rgbp[8];
        logic        hp[8];
        logic [7:0]  fmask;
        logic [15:0] s;
        logic [7:0]  expv;
        logic        h, v;

        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset with the first scenario's inputs already applied
        mode = 2'b01; display_on = 1'b1; rgb_in = 6'h00;
        hsync_in = 1'b1; vsync_in = 1'b1; noise_mask = 8'hFF;
        repeat (3) tick();
        check("reset_uo", 32'(uo_out), 32'h00);
        check("reset_fc", 32'(frame_count), 32'h0);
        reset = 1'b0;
        chk_on = 1'b1;
        tick();
        check("cont_clk1", 32'(uo_out), 32'h88);
        tick();
        check("cont_clk2", 32'(uo_out), 32'hA8);
        check("cont_active", 32'(noise_active), 32'h1);

        // Mode off passes the clean byte
        mode = 2'b00; rgb_in = 6'h3F;
        tick();
        check("off_uo", 32'(uo_out), 32'hFF);
        check("off_active", 32'(noise_active), 32'h0);

        // Blanking: colour bits zero, syncs pass through
        display_on = 1'b0; mode = 2'b01; noise_mask = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            h = 1'($urandom_range(0, 1)); v = 1'($urandom_range(0, 1));
            hsync_in = h; vsync_in = v; rgb_in = 6'($urandom);
            tick();
            check("blank_colour", 32'(uo_out & 8'h77), 32'h0);
            check("blank_sync", 32'({uo_out[7], uo_out[3]}), 32'({h, v}));
        end

        // Burst: two noisy frames, two cool frames, repeat
        display_on = 1'b1; vsync_in = 1'b1; mode = 2'b00;
        repeat (2) tick();
        mode = 2'b10; burst_len = 4'd2;
        for (int f = 0; f < 6; f++) begin
            vsync_in = 1'b0;
            tick();
            vsync_in = 1'b1;
            check("burst_pattern", 32'(noise_active), 32'(pat[f]));
            repeat (3) begin
                rgb_in = 6'($urandom);
                tick();
            end
        end

        // Frozen: identical per-pixel sequence in two consecutive frames
        mode = 2'b11; fmask = 8'($urandom);
        noise_mask = fmask;
        for (int k = 0; k < 8; k++) begin
            rgbp[k] = 6'($urandom); hp[k] = 1'($urandom_range(0, 1));
        end
        for (int f = 0; f < 2; f++) begin
            vsync_in = 1'b0;
            tick();
            s = TB_SEED;
            for (int k = 0; k < 8; k++) begin
                vsync_in = 1'b1; rgb_in = rgbp[k]; hsync_in = hp[k];
                tick();
                expv = clean(hp[k], 1'b1, 1'b1, rgbp[k]) ^ (perm(s) & fmask & 8'h77);
                check("frozen_pixel", 32'(uo_out), 32'(expv));
                s = pcg_next(s);
            end
        end

        // frame_count wrap
        mode = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            vsync_in = 1'b0; tick();
            vsync_in = 1'b1; tick();
        end
        check("fc_1023", 32'(frame_count), 32'd1023);
        vsync_in = 1'b0; tick();
        vsync_in = 1'b1; tick();
        check("fc_wrap", 32'(frame_count), 32'd0);

        // Reset mid-burst aborts at once and restarts from IDLE
        mode = 2'b10; burst_len = 4'd3;
        vsync_in = 1'b0; tick();
        vsync_in = 1'b1; tick();
        check("pre_reset_active", 32'(noise_active), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_burst_active", 32'(noise_active), 32'h0);
        tick();
        reset = 1'b0;
        burst_len = 4'd1;
        for (int f = 0; f < 3; f++) begin
            vsync_in = 1'b0; tick();
            vsync_in = 1'b1;
            check("restart_pattern", 32'(noise_active), 32'(f != 1));
            tick();
        end

        // Randomised traffic against the model
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) burst_len = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) noise_mask = 8'($urandom);
            vsync_in   = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            hsync_in   = 1'($urandom_range(0, 1));
            display_on = ($urandom_range(0, 3) != 0);
            rgb_in     = 6'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_noise_overlay.md
VGA_NOISE_OVERLAY -- requirements
Module: vga_noise_overlay

Interface
REQ-001 SHALL have parameter PCG_MUL, default 16'h5851, the PCG state multiplier.
REQ-002 SHALL have parameter PCG_INC, default 16'h1405, the PCG state increment.
REQ-003 SHALL have parameter SEED, default 16'h0000, the PCG state reset and reload value.
REQ-004 SHALL have parameter VSYNC_ACTIVE_HIGH, default 0, where 0 means vsync_in is asserted low.
REQ-005 SHALL have port clk  in  1  sole clock, all flops on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port hsync_in  in  1  hsync from the timing generator.
REQ-008 SHALL have port vsync_in  in  1  vsync from the timing generator.
REQ-009 SHALL have port display_on  in  1  visible-area flag.
REQ-010 SHALL have port rgb_in  in  6  pattern colour {R[1:0],G[1:0],B[1:0]}.
REQ-011 SHALL have port noise_mask  in  8  per-output-bit noise enable, aligned to uo_out.
REQ-012 SHALL have port mode  in  2  00 off, 01 continuous, 10 burst, 11 frozen.
REQ-013 SHALL have port burst_len  in  4  burst and cool length in frames.
REQ-014 SHALL have port uo_out  out  8  TinyVGA PMOD byte {hsync,B0,G0,R0,vsync,B1,G1,R1}.
REQ-015 SHALL have port frame_count  out  10  count of frame starts.
REQ-016 SHALL have port noise_active  out  1  noise currently applied.

Function
REQ-017 SHALL register uo_out with exactly 1 cycle latency from all video inputs.
REQ-018 SHALL compute the clean byte as {hsync_in,B0,G0,R0,vsync_in,B1,G1,R1}, with colour bits forced to 0 when display_on=0.
REQ-019 SHALL advance the 16-bit PCG state every cycle as state*PCG_MUL+PCG_INC, mod 2^16; this holds in every mode.
REQ-020 SHALL derive the noise word from the current state register as follows:
- x = (((s>>2)^s)>>3)[7:0]
- rot = s[5:3]
- noise = x rotated right by rot
REQ-021 SHALL make each uo_out bit equal clean XOR (noise & noise_mask & noise_en), with bits 7 and 3 never noised and colour bits never noised while display_on=0.
REQ-022 SHALL detect frame start as the cycle where the registered vsync_in goes from inactive to active level.
REQ-023 SHALL increment frame_count by 1 on each frame start, wrapping 1023->0.
REQ-024 SHALL compute noise_en combinationally as (mode==01) | (mode==11) | (mode==10 & fsm==BURST), and drive noise_active equal to noise_en.
REQ-025 SHALL, in mode 11, reload the PCG state to SEED on each frame start instead of advancing, giving identical noise every frame.
REQ-026 SHALL implement the burst FSM with states IDLE, BURST and COOL, and a 4-bit frames_left counter.
REQ-027 SHALL move the FSM from IDLE to BURST at a frame start with mode==10 and burst_len!=0, loading frames_left=burst_len; it SHALL stay in IDLE when burst_len==0.
REQ-028 SHALL decrement frames_left at each frame start in BURST or COOL; at a frame start with frames_left==1 it SHALL toggle BURST<->COOL and reload frames_left=burst_len, going to IDLE if burst_len==0.
REQ-029 SHALL force the FSM to IDLE on the next clock whenever mode!=10; this mode exit overrides a simultaneous frame start.
REQ-030 SHALL sample burst_len only at load/reload, so mid-burst changes do not alter the current period.

Reset
REQ-031 SHALL, on reset, asynchronously set: uo_out=8'h00, state=SEED, frame_count=0, FSM=IDLE, frames_left=0, and registered vsync=inactive level.
REQ-032 SHALL, on reset asserted mid-burst, abort the burst immediately and restart cleanly from IDLE after release.

Structure
REQ-033 SHALL place mode encodings, FSM state encodings and PMOD bit-index constants in the shared VGA package.
REQ-034 SHALL implement the PCG step and permutation as one sub-module, pcg8_gen, with ports clk, reset, reload and noise[7:0].

Verification
REQ-035 SHALL cover: reset, mode=01, display_on=1, rgb=0, hsync_in=vsync_in=1, mask=FF -> uo_out=88 after clock 1, A8 after clock 2.
REQ-036 SHALL cover: mode=00, rgb=3F, display_on=1, syncs 1 -> uo_out=FF after one clock; noise_active=0.
REQ-037 SHALL cover: display_on=0, mode=01, mask=FF -> colour bits 0 every cycle and sync bits equal the inputs.
REQ-038 SHALL cover: mode=10, burst_len=2, six frame starts -> noise_active pattern per frame 1,1,0,0,1,1.
REQ-039 SHALL cover: mode=11, two frames -> per-pixel uo_out sequence identical in both frames.
REQ-040 SHALL cover: 1024 frame starts -> frame_count wraps to 0; reset during BURST -> noise_active=0 and FSM=IDLE at once.
